// File: rtl/addsub_seq_unit.sv
// rtl/addsub_seq_unit.sv - multi-cycle sliced integer add/subtract unit with valid/ready handshakes
module addsub_seq_unit #(
   parameter  int WIDTH = 64,
   parameter  int CHUNK = 16,
   localparam int NSEG  = WIDTH / CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   input  logic             maluOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = (NSEG > 1) ? $clog2(NSEG) : 1;

   // A slice width that does not tile the operand cannot be built.
   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("addsub_seq_unit: CHUNK must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_reg, b_reg, acc;
   logic             c_reg;
   logic [CW-1:0]    cnt;
   logic             accept, last_seg;
   logic [31:0]      idx;
   logic [CHUNK-1:0] a_s, b_s;
   logic [CHUNK:0]   sum_s;
   logic [WIDTH-1:0] slice_mask, acc_nxt;

   assign accept   = in_valid & in_ready;
   assign last_seg = (cnt == CW'(NSEG - 1));

   // State register; reset abandons any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (accept) state_nxt = BUSY;
         end
         BUSY: begin
            if (last_seg) state_nxt = DONE;
         end
         DONE: begin
            out_valid = ~rst;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Current slice sum and the accumulator with that slice merged in.
   always_comb begin
      idx        = 32'(cnt) * 32'(CHUNK);
      a_s        = CHUNK'(a_reg >> idx);
      b_s        = CHUNK'(b_reg >> idx);
      sum_s      = {1'b0, a_s} + {1'b0, b_s} + (CHUNK + 1)'(c_reg);
      slice_mask = WIDTH'({CHUNK{1'b1}}) << idx;
      acc_nxt    = (acc & ~slice_mask) | (WIDTH'(sum_s[CHUNK-1:0]) << idx);
   end

   // Operand capture, per-slice accumulation, and result/flag load on DONE entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         acc      <= '0;
         c_reg    <= 1'b0;
         cnt      <= '0;
         res      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg <= inp1;
                  b_reg <= maluOp ? inp2 : ~inp2;
                  c_reg <= ~maluOp;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               acc   <= acc_nxt;
               c_reg <= sum_s[CHUNK];
               cnt   <= cnt + CW'(1);
               if (last_seg) begin
                  res      <= acc_nxt;
                  carry    <= sum_s[CHUNK];
                  overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &
                              (acc_nxt[WIDTH-1] != a_reg[WIDTH-1]);
                  zero     <= (acc_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
